// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline.
// It handles the power-up start hold, load-use bubbles, branch squashes, memory-busy freezes and perf counters.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             start_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {INIT, RUN, FREEZE} state_t;

  state_t            state_reg, state_next;
  logic [INIT_W-1:0] init_cnt_reg, init_cnt_next;
  logic              pend_flush_reg, pend_flush_next;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;
  logic              stall_inc, flush_inc;
  logic              load_use, branch_eff;

  assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  // A branch seen while frozen is replayed on the first non-busy cycle.
  assign branch_eff = branch_taken_i || ((state_reg == FREEZE) && pend_flush_reg);

  always_comb begin
    state_next      = state_reg;
    init_cnt_next   = init_cnt_reg;
    pend_flush_next = pend_flush_reg;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    start_o         = 1'b0;
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b1;
    id_ex_flush_o   = 1'b1;
    stall_o         = 1'b1;

    case (state_reg)
      INIT: begin
        if (init_cnt_reg == '0) state_next = RUN;
        else                    init_cnt_next = init_cnt_reg - INIT_W'(1);
      end
      RUN, FREEZE: begin
        start_o = 1'b1;
        if (mem_busy_i) begin
          if_id_flush_o   = 1'b0;
          id_ex_flush_o   = 1'b0;
          state_next      = FREEZE;
          pend_flush_next = ((state_reg == FREEZE) && pend_flush_reg) || branch_taken_i;
          stall_inc       = 1'b1;
        end else begin
          state_next      = RUN;
          pend_flush_next = 1'b0;
          stall_o         = 1'b0;
          if (branch_eff) begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            flush_inc     = 1'b1;
          end else if (load_use) begin
            if_id_flush_o = 1'b0;
            stall_inc     = 1'b1;
          end else begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            if_id_flush_o = 1'b0;
            id_ex_flush_o = 1'b0;
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= INIT;
      init_cnt_reg   <= INIT_LOAD;
      pend_flush_reg <= 1'b0;
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      init_cnt_reg   <= init_cnt_next;
      pend_flush_reg <= pend_flush_next;
      if (stall_inc && (stall_cnt_reg != CNT_MAX)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_inc && (flush_cnt_reg != CNT_MAX)) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a wide-counter and a 2-bit-counter instance share stimulus.
// A cycle-level model is checked every negedge, plus directed literal checks.
module tb_pipeline_hazard_ctrl;

  localparam int INIT_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       uses_rt = 1'b0, ex_memread = 1'b0, branch = 1'b0, mem_busy = 1'b0;

  logic        start_a, pc_a, ifw_a, iff_a, idf_a, stall_a;
  logic        start_b, pc_b, ifw_b, iff_b, idf_b, stall_b;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [1:0]  stall_cnt_b, flush_cnt_b;
  logic [5:0]  vec_a, vec_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch), .mem_busy_i(mem_busy),
    .start_o(start_a), .pc_write_o(pc_a), .if_id_write_o(ifw_a), .if_id_flush_o(iff_a),
    .id_ex_flush_o(idf_a), .stall_o(stall_a), .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
  );

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch), .mem_busy_i(mem_busy),
    .start_o(start_b), .pc_write_o(pc_b), .if_id_write_o(ifw_b), .if_id_flush_o(iff_b),
    .id_ex_flush_o(idf_b), .stall_o(stall_b), .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
  );

  assign vec_a = {start_a, pc_a, ifw_a, iff_a, idf_a, stall_a};
  assign vec_b = {start_b, pc_b, ifw_b, iff_b, idf_b, stall_b};

  // Model: edges left before start, frozen flag, remembered branch, raw (unsaturated) event counts.
  int m_init_left = INIT_CYCLES;
  bit m_frozen = 1'b0;
  bit m_pend = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic bit hazard();
    return ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

  // Output vector order: start, pc_write, if_id_write, if_id_flush, id_ex_flush, stall.
  function automatic logic [5:0] model_vec();
    if (rst || (m_init_left > 0))  return 6'b000111;
    if (mem_busy)                  return 6'b100001;
    if (branch || m_pend)          return 6'b111110;
    if (hazard())                  return 6'b100010;
    return 6'b111000;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_init_left <= INIT_CYCLES;
      m_frozen    <= 1'b0;
      m_pend      <= 1'b0;
      m_stall     <= 0;
      m_flush     <= 0;
    end else if (m_init_left > 0) begin
      m_init_left <= m_init_left - 1;
    end else if (mem_busy) begin
      m_frozen <= 1'b1;
      m_pend   <= m_pend | branch;
      m_stall  <= m_stall + 1;
    end else begin
      if (branch || m_pend) m_flush <= m_flush + 1;
      else if (hazard())    m_stall <= m_stall + 1;
      m_frozen <= 1'b0;
      m_pend   <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] ev;
    ev = model_vec();
    chk("model_outs_a", int'(vec_a), int'(ev));
    chk("model_outs_b", int'(vec_b), int'(ev));
    chk("model_stall_cnt_a", int'(stall_cnt_a), m_stall);
    chk("model_flush_cnt_a", int'(flush_cnt_a), m_flush);
    chk("model_stall_cnt_b", int'(stall_cnt_b), sat3(m_stall));
    chk("model_flush_cnt_b", int'(flush_cnt_b), sat3(m_flush));
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    uses_rt = 1'b0; ex_memread = 1'b0; branch = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    chk("rst_start", int'(start_a), 0);
    chk("rst_stall", int'(stall_a), 1);
    chk("rst_flushes", int'({iff_a, idf_a}), 3);
    advance();
    rst = 1'b0;

    // Start hold for INIT_CYCLES edges
    @(negedge clk); chk("init_start0", int'(start_a), 0);
    advance();
    @(negedge clk); chk("init_start1", int'(start_a), 0); chk("init_pc", int'(pc_a), 0);
    advance();
    @(negedge clk); chk("run_start", int'(start_a), 1); chk("run_pc", int'(pc_a), 1);
    advance();

    // Load-use on rs
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    @(negedge clk);
    chk("lu_pc", int'(pc_a), 0); chk("lu_ifw", int'(ifw_a), 0);
    chk("lu_idf", int'(idf_a), 1); chk("lu_cnt_before", int'(stall_cnt_a), 0);
    advance();
    ex_memread = 1'b0;
    @(negedge clk); chk("lu_cnt_after", int'(stall_cnt_a), 1); chk("lu_next_pc", int'(pc_a), 1);
    advance();

    // $0 never hazards
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk); chk("r0_pc", int'(pc_a), 1);
    advance();
    @(negedge clk); chk("r0_cnt", int'(stall_cnt_a), 1);
    advance();

    // rt match only counts when rt is a source
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; uses_rt = 1'b0;
    @(negedge clk); chk("rt_unused_pc", int'(pc_a), 1);
    advance();
    uses_rt = 1'b1;
    @(negedge clk); chk("rt_used_pc", int'(pc_a), 0);
    advance();

    // Branch overrides load-use
    branch = 1'b1;
    @(negedge clk);
    chk("br_iff", int'(iff_a), 1); chk("br_idf", int'(idf_a), 1); chk("br_pc", int'(pc_a), 1);
    advance();
    idle();
    @(negedge clk); chk("br_flush_cnt", int'(flush_cnt_a), 1); chk("br_stall_cnt", int'(stall_cnt_a), 2);
    advance();

    // Three busy cycles with a branch in the middle one
    mem_busy = 1'b1;
    @(negedge clk); chk("fz_stall", int'(stall_a), 1); chk("fz_pc", int'(pc_a), 0);
    advance();
    branch = 1'b1;
    advance();
    branch = 1'b0;
    advance();
    mem_busy = 1'b0;
    @(negedge clk);
    chk("fz_pend_iff", int'(iff_a), 1); chk("fz_pend_idf", int'(idf_a), 1);
    chk("fz_stall_cnt", int'(stall_cnt_a), 5); chk("fz_sat_b", int'(stall_cnt_b), 3);
    advance();
    @(negedge clk); chk("fz_pend_clear", int'(iff_a), 0); chk("fz_flush_cnt", int'(flush_cnt_a), 2);
    advance();

    // Continuous hazard: narrow counter pins at 3
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    repeat (6) advance();
    @(negedge clk); chk("sat_b", int'(stall_cnt_b), 3); chk("sat_a", int'(stall_cnt_a), 11);
    advance();
    idle();

    // Reset in the middle of a freeze, with a pending branch
    mem_busy = 1'b1; branch = 1'b1;
    advance();
    branch = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_start", int'(start_a), 0); chk("arst_stall", int'(stall_a), 1);
    chk("arst_iff", int'(iff_a), 1); chk("arst_pc", int'(pc_a), 0);
    chk("arst_stall_cnt", int'(stall_cnt_a), 0); chk("arst_flush_cnt", int'(flush_cnt_a), 0);
    mem_busy = 1'b0;
    advance();
    rst = 1'b0;
    @(negedge clk); chk("reinit_start0", int'(start_a), 0);
    advance();
    @(negedge clk); chk("reinit_start1", int'(start_a), 0);
    advance();
    @(negedge clk);
    chk("reinit_run", int'(start_a), 1); chk("reinit_no_pend", int'(iff_a), 0); chk("reinit_pc", int'(pc_a), 1);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
